// File: rtl/rgb_yuv_pipe.sv
`default_nettype none
// ==========================================================================
// rgb_yuv_pipe
// Four-stage RGB to YUV converter, per-pixel BT.601/BT.709, valid/ready flow.
// Revision: 1.0
// ==========================================================================
module rgb_yuv_pipe #(
  parameter int DW = 16,
  parameter int CF = 15
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] gdata,
  input  logic [DW-1:0] bdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ydata,
  output logic [DW:0]   udata,
  output logic [DW:0]   vdata
);

  localparam int PW  = DW + 15;  // unsigned Y product width
  localparam int SW  = DW + 17;  // Y sum width (three products plus rounding)
  localparam int CPW = DW + 17;  // signed chroma product width
  localparam int YQW = DW + 2;   // quotient width before saturation/clamp

  localparam logic [14:0] c_k601_r = 15'd9798;
  localparam logic [14:0] c_k601_g = 15'd19235;
  localparam logic [14:0] c_k601_b = 15'd3736;
  localparam logic [14:0] c_k709_r = 15'd6967;
  localparam logic [14:0] c_k709_g = 15'd23436;
  localparam logic [14:0] c_k709_b = 15'd2365;
  localparam logic [14:0] c_k601_u = 15'd16122;
  localparam logic [14:0] c_k601_v = 15'd28738;
  localparam logic [14:0] c_k709_u = 15'd17659;
  localparam logic [14:0] c_k709_v = 15'd20808;

  localparam logic [SW-1:0]         c_yrnd = SW'(2 ** (CF - 1));
  localparam logic signed [CPW-1:0] c_crnd = CPW'(2 ** (CF - 1));

  generate
    if (CF != 15) begin : g_bad_cf
      $error("rgb_yuv_pipe: CF must be 15");
    end
    if (DW < 8 || DW > 16) begin : g_bad_dw
      $error("rgb_yuv_pipe: DW must be in 8..16");
    end
  endgenerate

  logic w_ce;
  assign w_ce     = !out_valid | out_ready;
  assign in_ready = w_ce;

  // Stage 1: full-precision Y products
  logic [14:0]   w_kr, w_kg, w_kb;
  logic          r1_valid, r1_mode;
  logic [DW-1:0] r1_r, r1_b;
  logic [PW-1:0] r1_pr, r1_pg, r1_pb;

  assign w_kr = in_mode ? c_k709_r : c_k601_r;
  assign w_kg = in_mode ? c_k709_g : c_k601_g;
  assign w_kb = in_mode ? c_k709_b : c_k601_b;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_mode  <= 1'b0;
      r1_r     <= '0;
      r1_b     <= '0;
      r1_pr    <= '0;
      r1_pg    <= '0;
      r1_pb    <= '0;
    end else if (w_ce) begin
      r1_valid <= in_valid;
      r1_mode  <= in_mode;
      r1_r     <= rdata;
      r1_b     <= bdata;
      r1_pr    <= PW'(rdata) * PW'(w_kr);
      r1_pg    <= PW'(gdata) * PW'(w_kg);
      r1_pb    <= PW'(bdata) * PW'(w_kb);
    end
  end

  // Stage 2: rounded Y; BT.601 coefficients sum past unity so white can exceed full scale
  logic [SW-1:0]  w_sum;
  logic [YQW-1:0] w_yq;
  logic [DW-1:0]  w_ysat;
  logic           r2_valid, r2_mode;
  logic [DW-1:0]  r2_y, r2_r, r2_b;

  assign w_sum  = SW'(r1_pr) + SW'(r1_pg) + SW'(r1_pb) + c_yrnd;
  assign w_yq   = YQW'(w_sum >> CF);
  assign w_ysat = (w_yq[YQW-1:DW] != 2'b00) ? {DW{1'b1}} : w_yq[DW-1:0];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_mode  <= 1'b0;
      r2_y     <= '0;
      r2_r     <= '0;
      r2_b     <= '0;
    end else if (w_ce) begin
      r2_valid <= r1_valid;
      r2_mode  <= r1_mode;
      r2_y     <= w_ysat;
      r2_r     <= r1_r;
      r2_b     <= r1_b;
    end
  end

  // Stage 3: colour differences
  logic               r3_valid, r3_mode;
  logic [DW-1:0]      r3_y;
  logic signed [DW:0] r3_by, r3_ry;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid <= 1'b0;
      r3_mode  <= 1'b0;
      r3_y     <= '0;
      r3_by    <= '0;
      r3_ry    <= '0;
    end else if (w_ce) begin
      r3_valid <= r2_valid;
      r3_mode  <= r2_mode;
      r3_y     <= r2_y;
      r3_by    <= $signed({1'b0, r2_b}) - $signed({1'b0, r2_y});
      r3_ry    <= $signed({1'b0, r2_r}) - $signed({1'b0, r2_y});
    end
  end

  // Stage 4: scaled chroma, floor shift, clamp to the signed output range
  logic [14:0]           w_ku, w_kv;
  logic signed [CPW-1:0] w_up, w_vp;
  logic [YQW-1:0]        w_uq, w_vq;

  assign w_ku = r3_mode ? c_k709_u : c_k601_u;
  assign w_kv = r3_mode ? c_k709_v : c_k601_v;
  assign w_up = CPW'(r3_by) * CPW'($signed({1'b0, w_ku})) + c_crnd;
  assign w_vp = CPW'(r3_ry) * CPW'($signed({1'b0, w_kv})) + c_crnd;
  assign w_uq = YQW'(w_up >>> CF);
  assign w_vq = YQW'(w_vp >>> CF);

  function automatic logic [DW:0] clamp_c(input logic [YQW-1:0] x);
    if (x[YQW-1] != x[DW])
      return x[YQW-1] ? {1'b1, {DW{1'b0}}} : {1'b0, {DW{1'b1}}};
    return x[DW:0];
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ydata     <= '0;
      udata     <= '0;
      vdata     <= '0;
    end else if (w_ce) begin
      out_valid <= r3_valid;
      ydata     <= r3_y;
      udata     <= clamp_c(w_uq);
      vdata     <= clamp_c(w_vq);
    end
  end

endmodule
`default_nettype wire
